// File: rtl/decimal_keypad_controller.sv
// decimal_keypad_controller
//   Front-end sequencer for a 10-line decimal keypad. It registers the raw key
//   lines, debounces presses and releases, rejects multi-key presses, shifts
//   accepted digits (BCD) into a multi-digit accumulator, and commits the
//   accumulated number to a valid/ready output when enter is requested.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a press/release (>=1)
//   DIGITS          : BCD digits held in the accumulator (1..8)
//
// Ports
//   clk          : system clock, rising edge
//   rst          : synchronous reset, active-high
//   key[9:0]     : raw key lines, bit i = decimal key i (already synchronous)
//   enter        : single-cycle commit request
//   clear        : single-cycle accumulator clear
//   bcd_out      : committed number, most recently entered digit in [3:0]
//   out_valid    : bcd_out holds an unconsumed value
//   out_ready    : consumer takes bcd_out when out_valid & out_ready
//   digit_count  : digits currently held in the accumulator
//   key_err      : one-cycle pulse on a multi-key press or accumulator overflow
//
// Build option
//   KEYPAD_AUTO_ENTER_EN : when defined, the capture that fills the accumulator
//   also commits it on the same edge, provided the output can accept a value.

module decimal_keypad_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DIGITS          = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   key,
  input  logic                         enter,
  input  logic                         clear,
  output logic [4*DIGITS-1:0]          bcd_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         key_err
);

  localparam int CW   = $clog2(DIGITS + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   MAX_CNT = CW'(DIGITS);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_DB   = 2'd1;
  localparam logic [1:0] RELEASE_DB = 2'd2;

  logic [9:0]          key_q;
  logic [DB_W-1:0]     db_cnt;
  logic [1:0]          state;
  logic [4*DIGITS-1:0] acc;

  logic                key_onehot;
  logic                db_done;
  logic                press_done;
  logic                capture;
  logic                multi_err;
  logic                can_take;
  logic                sink_free;
  logic                enter_ok;
  logic                auto_ok;
  logic                overflow_err;
  logic [3:0]          key_bcd;
  logic [4*DIGITS-1:0] acc_shift;

  // A value with exactly one bit set has no bits in common with itself minus one.
  assign key_onehot = (key_q != 10'd0) && ((key_q & (key_q - 10'd1)) == 10'd0);
  assign db_done    = (db_cnt == DB_MAX);
  assign press_done = (state == PRESS_DB) && db_done && (key_q != 10'd0);
  assign capture    = press_done && key_onehot;
  assign multi_err  = press_done && !key_onehot;
  assign can_take   = (digit_count < MAX_CNT);
  assign sink_free  = !out_valid || out_ready;
  assign enter_ok   = enter && !clear && (digit_count != '0) && sink_free;

`ifdef KEYPAD_AUTO_ENTER_EN
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);
  assign auto_ok = capture && !clear && sink_free && (digit_count == LAST_CNT);
`else
  assign auto_ok = 1'b0;
`endif

  // A digit that arrives while the accumulator is full is dropped; when an
  // enter is accepted on the same edge the digit starts the next number instead.
  assign overflow_err = capture && !can_take && !enter_ok && !clear;

  always_comb begin
    key_bcd = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key_q[i]) key_bcd = 4'(i);
    end
  end

  generate
    if (DIGITS == 1) begin : g_shift_one
      assign acc_shift = key_bcd;
    end else begin : g_shift_many
      assign acc_shift = {acc[4*DIGITS-5:0], key_bcd};
    end
  endgenerate

  // key_q register and debounce counter. The counter compares the incoming
  // sample with the current key_q, so it equals the number of consecutive
  // edges key_q has held its present value (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= 10'd0;
      db_cnt <= '0;
    end else begin
      key_q <= key;
      if (key != key_q)  db_cnt <= '0;
      else if (!db_done) db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Press/release sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (key_q != 10'd0) state <= PRESS_DB;
        end
        PRESS_DB: begin
          if (key_q == 10'd0) state <= IDLE;
          else if (db_done)   state <= RELEASE_DB;
        end
        RELEASE_DB: begin
          if ((key_q == 10'd0) && db_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accumulator, output register and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      digit_count <= '0;
      bcd_out     <= '0;
      out_valid   <= 1'b0;
      key_err     <= 1'b0;
    end else begin
      key_err <= multi_err || overflow_err;

      if (clear) begin
        acc         <= '0;
        digit_count <= '0;
      end else if (auto_ok) begin
        acc         <= '0;
        digit_count <= '0;
      end else if (enter_ok) begin
        if (capture) begin
          acc         <= {{(4*DIGITS-4){1'b0}}, key_bcd};
          digit_count <= CW'(1);
        end else begin
          acc         <= '0;
          digit_count <= '0;
        end
      end else if (capture && can_take) begin
        acc         <= acc_shift;
        digit_count <= digit_count + CW'(1);
      end

      if (auto_ok) begin
        bcd_out   <= acc_shift;
        out_valid <= 1'b1;
      end else if (enter_ok) begin
        bcd_out   <= acc;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decimal_keypad_controller.sv
// tb_decimal_keypad_controller
//   Directed and randomized checks of decimal_keypad_controller against a
//   digit-queue reference model (DEBOUNCE_CYCLES=4, DIGITS=4).

module tb_decimal_keypad_controller;

  localparam int D = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [9:0]     key;
  logic           enter;
  logic           clear;
  logic [4*N-1:0] bcd_out;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     digit_count;
  logic           key_err;

  always #5 clk = ~clk;

  decimal_keypad_controller #(.DEBOUNCE_CYCLES(D), .DIGITS(N)) dut (
    .clk(clk), .rst(rst), .key(key), .enter(enter), .clear(clear),
    .bcd_out(bcd_out), .out_valid(out_valid), .out_ready(out_ready),
    .digit_count(digit_count), .key_err(key_err)
  );

  // key_err cycles observed so far
  int err_total = 0;
  always @(negedge clk) if (key_err === 1'b1) err_total++;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: digits held (oldest first), output register, expected errors
  int             mq[$];
  bit             m_valid;
  logic [4*N-1:0] m_bcd;
  int             exp_err;
  int             err_base;

  function automatic logic [4*N-1:0] acc_val();
    logic [4*N-1:0] v = '0;
    foreach (mq[i]) v = (v << 4) | (4*N)'(mq[i]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_bcd   = '0;
  endtask

  task automatic model_commit();
    m_bcd   = acc_val();
    m_valid = 1'b1;
    mq.delete();
  endtask

  task automatic step_begin();
    err_base = err_total;
    exp_err  = 0;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    check({tag, ".count"}, 64'(digit_count), 64'(mq.size()));
    check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".bcd"}, 64'(bcd_out), 64'(m_bcd));
    check({tag, ".err"}, 64'(err_total - err_base), 64'(exp_err));
    $display("step %-14s count=%0d valid=%0b bcd=%h errs=%0d", tag, digit_count, out_valid,
             bcd_out, err_total - err_base);
  endtask

  // Drive k for 'hold' edges, release, and wait out the release debounce.
  // do_clr pulses clear into the edge on which the digit would be captured.
  task automatic press(input logic [9:0] k, input int hold, input bit do_clr);
    bit onehot;
    int idx;
    key = k;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk); #1;
      clear = do_clr && (i == D + 1);
    end
    key   = 10'd0;
    clear = 1'b0;
    repeat (D + 4) @(posedge clk);
    #1;
    onehot = (k != 0) && ((k & (k - 10'd1)) == 10'd0);
    idx = 0;
    for (int b = 0; b < 10; b++) if (k[b]) idx = b;
    if (hold >= D + 2) begin
      if (!onehot) exp_err++;
      if (do_clr) mq.delete();
      else if (onehot) begin
        if (mq.size() < N) begin
          mq.push_back(idx);
`ifdef KEYPAD_AUTO_ENTER_EN
          if (mq.size() == N && !m_valid) model_commit();
`endif
        end else begin
          exp_err++;
        end
      end
    end
  endtask

  task automatic do_enter(input bit ready);
    enter = 1'b1;
    out_ready = ready;
    @(posedge clk); #1;
    enter = 1'b0;
    out_ready = 1'b0;
    if (mq.size() > 0 && (!m_valid || ready)) model_commit();
    else if (ready) m_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mq.delete();
  endtask

  initial begin
    int seq_a[4];
    int seq_b[4];
    int a;
    int b;
    int op;
    logic [9:0] kk;

    rst = 1'b1; key = '0; enter = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    step_begin();
    repeat (3) @(posedge clk);
    check_all("reset");
    check("reset.key_err", 64'(key_err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // single key 3: latency check, then commit to see the captured digit
    step_begin();
    key = 10'b0000001000;
    repeat (D + 1) @(posedge clk);
    @(negedge clk);
    check("lat_before", 64'(digit_count), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("lat_after", 64'(digit_count), 64'(1));
    repeat (8 - (D + 2)) @(posedge clk);
    #1 key = 10'd0;
    repeat (D + 4) @(posedge clk);
    #1;
    mq.push_back(3);
    check_all("key3");
    do_enter(1'b0);
    check_all("key3_enter");
    check("key3_bcd", 64'(bcd_out), 64'h3);
    consume();
    check_all("key3_consume");

    // glitch shorter than the debounce window
    step_begin();
    press(10'b0010000000, 3, 1'b0);
    check_all("glitch7");

    // 1,9,0,5 then enter with consumer stalled
    step_begin();
    seq_a = '{1, 9, 0, 5};
    foreach (seq_a[i]) press(10'(1) << seq_a[i], 8, 1'b0);
    do_enter(1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_all("n1905_hold");
    check("n1905_bcd", 64'(bcd_out), 64'h1905);
    consume();
    check_all("n1905_consume");
    check("n1905_drop", 64'(out_valid), 64'(0));

    // multi-key press, then overflow
    step_begin();
    press(10'b0000100100, 8, 1'b0);
    check_all("multi25");
    step_begin();
    for (int i = 0; i < 5; i++) press(10'(1) << $urandom_range(0, 9), 8, 1'b0);
    check_all("overflow");
    do_clear();
    if (m_valid) consume();
    step_begin();
    check_all("clear");

    // clear coinciding with capture, then enter on an empty accumulator
    step_begin();
    press(10'b0000000100, 8, 1'b0);
    press(10'b0001000000, 8, 1'b0);
    press(10'b0000010000, 8, 1'b1);
    check_all("clr_capture");
    do_enter(1'b0);
    check_all("enter_empty");

`ifdef KEYPAD_AUTO_ENTER_EN
    step_begin();
    seq_b = '{4, 3, 2, 1};
    foreach (seq_b[i]) press(10'(1) << seq_b[i], 8, 1'b0);
    check_all("auto4321");
    check("auto_bcd", 64'(bcd_out), 64'h4321);
    consume();
`else
    seq_b = '{0, 0, 0, 0};
`endif

    // reset while a key is held, with state built up beforehand
    step_begin();
    press(10'b0000000010, 8, 1'b0);
    do_enter(1'b0);
    press(10'b0000001000, 8, 1'b0);
    check_all("pre_reset");
    step_begin();
    key = 10'b1000000000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    check_all("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    key = 10'd0;
    repeat (D + 4) @(posedge clk);
    #1;
    check_all("post_reset");

    // randomized operations
    for (int it = 0; it < 40; it++) begin
      step_begin();
      op = $urandom_range(0, 10);
      if (op <= 5) begin
        press(10'(1) << $urandom_range(0, 9), $urandom_range(D + 2, D + 6), 1'b0);
      end else if (op == 6) begin
        kk = 10'(1) << $urandom_range(0, 9);
        if ($urandom_range(0, 1) == 1) kk = kk | (10'(1) << $urandom_range(0, 9));
        press(kk, $urandom_range(1, D), 1'b0);
      end else if (op == 7) begin
        a = $urandom_range(0, 9);
        b = (a + 1 + $urandom_range(0, 8)) % 10;
        press((10'(1) << a) | (10'(1) << b), $urandom_range(D + 2, D + 6), 1'b0);
      end else if (op == 8) begin
        do_enter(1'($urandom_range(0, 1)));
      end else if (op == 9) begin
        consume();
      end else begin
        do_clear();
      end
      check_all($sformatf("rnd%0d_op%0d", it, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
